ctrl_pipe: RTL and testbench

Pipelined, hazard-aware control unit for the 4-bit-opcode datapath. It decodes the opcode in ID and carries the resulting control bundle, together with destination-register and valid tags, through EX, MEM and WB stage registers. It detects load-use hazards and stalls ID, squashes wrong-path instructions on a redirect, and counts stall cycles. It sits between the instruction register and the datapath stage muxes, and replaces the purely combinational decoder.

---
 rtl/ctrl_pipe_pkg.sv | 97 +++++++++
 rtl/ctrl_pipe_decode.sv | 30 +++
 rtl/ctrl_pipe.sv | 107 ++++++++++
 tb/tb_ctrl_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and the opcode decode function for the pipelined control unit.
package ctrl_pipe_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LD   = 4'b0001;
  localparam logic [3:0] OP_ST   = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_INC  = 4'b0101;
  localparam logic [3:0] OP_NEG  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_BRZ  = 4'b1001;
  localparam logic [3:0] OP_BRN  = 4'b1011;
  localparam logic [3:0] OP_ADDI = 4'b1111;

  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_INC  = 3'b010;
  localparam logic [2:0] ALU_NEG  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b000;
  localparam logic [2:0] ALU_PASS = 3'b111;
  localparam logic [2:0] ALU_NOP  = 3'b011;

  localparam int CTRL_W     = 12;
  localparam int B_VALID    = 11;
  localparam int B_REGWRT   = 10;
  localparam int B_MEMRD    = 9;
  localparam int B_MEMWRT   = 8;
  localparam int B_ALUSRC   = 7;
  localparam int B_ALUOP_HI = 6;
  localparam int B_ALUOP_LO = 4;
  localparam int B_MEMTOREG = 3;
  localparam int B_BRANCH   = 2;
  localparam int B_BTYPE    = 1;
  localparam int B_JUMP     = 0;

  // Everything cleared except aluop=NOP.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 12'h030;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic              reads_rs;
    logic              reads_rt;
    logic              illegal;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] op);
    dec_t d;
    d.ctrl          = CTRL_BUBBLE;
    d.ctrl[B_VALID] = 1'b1;
    d.reads_rs      = 1'b0;
    d.reads_rt      = 1'b0;
    d.illegal       = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LD: begin
        d.ctrl[B_REGWRT]   = 1'b1;
        d.ctrl[B_MEMRD]    = 1'b1;
        d.ctrl[B_MEMTOREG] = 1'b1;
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_PASS;
      end
      OP_ST: begin
        d.ctrl[B_MEMWRT] = 1'b1;
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_PASS;
        d.reads_rs = 1'b1;
        d.reads_rt = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        d.ctrl[B_REGWRT] = 1'b1;
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
        d.reads_rs = 1'b1;
        d.reads_rt = 1'b1;
      end
      OP_INC, OP_NEG: begin
        d.ctrl[B_REGWRT] = 1'b1;
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = (op == OP_INC) ? ALU_INC : ALU_NEG;
        d.reads_rs = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl[B_REGWRT] = 1'b1;
        d.ctrl[B_ALUSRC] = 1'b1;
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_ADD;
      end
      OP_J: begin
        d.ctrl[B_JUMP] = 1'b1;
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_PASS;
      end
      OP_BRZ, OP_BRN: begin
        d.ctrl[B_BRANCH] = 1'b1;
        d.ctrl[B_BTYPE]  = (op == OP_BRN);
        d.ctrl[B_ALUOP_HI:B_ALUOP_LO] = ALU_PASS;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational ID-stage decoder: opcode plus valid flag to control bundle and source-read flags.
module ctrl_decode
  import ctrl_pipe_pkg::*;
(
  input  logic              i_valid,
  input  logic [3:0]        i_opcode,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_reads_rs,
  output logic              o_reads_rt,
  output logic              o_illegal
);

  dec_t w_dec;

  always_comb begin
    w_dec = decode(i_opcode);
    if (!i_valid) begin
      w_dec.ctrl     = CTRL_BUBBLE;
      w_dec.reads_rs = 1'b0;
      w_dec.reads_rt = 1'b0;
      w_dec.illegal  = 1'b0;
    end
  end

  assign o_ctrl     = w_dec.ctrl;
  assign o_reads_rs = w_dec.reads_rs;
  assign o_reads_rt = w_dec.reads_rt;
  assign o_illegal  = w_dec.illegal;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers, load-use stall and redirect squash.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 6,
  parameter int HAZARD_EN  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_valid,
  input  logic [3:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_redirect,
  output logic                  out_stall,
  output logic [CTRL_W-1:0]     out_ex_ctrl,
  output logic [CTRL_W-1:0]     out_mem_ctrl,
  output logic [CTRL_W-1:0]     out_wb_ctrl,
  output logic [REG_ADDR_W-1:0] out_ex_rd,
  output logic [REG_ADDR_W-1:0] out_mem_rd,
  output logic [REG_ADDR_W-1:0] out_wb_rd,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      out_stall_cnt
);

  logic [CTRL_W-1:0]     r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [REG_ADDR_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
  logic                  r_illegal;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic [CTRL_W-1:0] w_id_ctrl;
  logic              w_reads_rs, w_reads_rt, w_illegal;
  logic              w_hazard, w_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  ctrl_decode u_decode (
    .i_valid    (in_valid),
    .i_opcode   (in_opcode),
    .o_ctrl     (w_id_ctrl),
    .o_reads_rs (w_reads_rs),
    .o_reads_rt (w_reads_rt),
    .o_illegal  (w_illegal)
  );

  // Register 0 is hardwired, so a load targeting it never blocks a consumer.
  always_comb begin
    w_hazard = (HAZARD_EN != 0) && in_valid
               && r_ex_ctrl[B_VALID] && r_ex_ctrl[B_MEMRD]
               && (r_ex_rd != '0)
               && ((w_reads_rs && (in_rs == r_ex_rd)) ||
                   (w_reads_rt && (in_rt == r_ex_rd)));
  end

  assign w_stall   = w_hazard & ~in_redirect;
  assign out_stall = w_stall & ~in_rst;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_ex_ctrl   <= CTRL_BUBBLE;
      r_mem_ctrl  <= CTRL_BUBBLE;
      r_wb_ctrl   <= CTRL_BUBBLE;
      r_ex_rd     <= '0;
      r_mem_rd    <= '0;
      r_wb_rd     <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_wb_ctrl <= r_mem_ctrl;
      r_wb_rd   <= r_mem_rd;
      if (in_redirect) begin
        r_ex_ctrl  <= CTRL_BUBBLE;
        r_ex_rd    <= '0;
        r_mem_ctrl <= CTRL_BUBBLE;
        r_mem_rd   <= '0;
        r_illegal  <= 1'b0;
      end else if (w_stall) begin
        r_ex_ctrl   <= CTRL_BUBBLE;
        r_ex_rd     <= '0;
        r_mem_ctrl  <= r_ex_ctrl;
        r_mem_rd    <= r_ex_rd;
        r_illegal   <= 1'b0;
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_ex_ctrl  <= w_id_ctrl;
        r_ex_rd    <= (in_valid && !w_illegal) ? in_rd : '0;
        r_mem_ctrl <= r_ex_ctrl;
        r_mem_rd   <= r_ex_rd;
        r_illegal  <= w_illegal;
      end
    end
  end

  assign out_ex_ctrl   = r_ex_ctrl;
  assign out_mem_ctrl  = r_mem_ctrl;
  assign out_wb_ctrl   = r_wb_ctrl;
  assign out_ex_rd     = r_ex_rd;
  assign out_mem_rd    = r_mem_rd;
  assign out_wb_rd     = r_wb_rd;
  assign out_illegal   = r_illegal;
  assign out_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed test of ctrl_pipe: decode, load-use stall, redirect, illegal opcode, reset and counter saturation.
module tb_ctrl_pipe;

  localparam int RW = 6;
  localparam int CW = 2;

  // Hand-computed bundles {valid,regwrt,memrd,memwrt,alusrc,aluop[2:0],memtoreg,branch,btype,jump}
  localparam logic [11:0] E_BUB  = 12'h030;
  localparam logic [11:0] E_ILL  = 12'h830;
  localparam logic [11:0] E_ADD  = 12'hC40;
  localparam logic [11:0] E_SUB  = 12'hC00;
  localparam logic [11:0] E_INC  = 12'hC20;
  localparam logic [11:0] E_LD   = 12'hE78;
  localparam logic [11:0] E_BRZ  = 12'h874;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vld = 1'b0;
  logic [3:0]    op  = 4'b0000;
  logic [RW-1:0] rs  = '0, rt = '0, rd = '0;
  logic          redir = 1'b0;
  logic          stall;
  logic [11:0]   ex_ctrl, mem_ctrl, wb_ctrl;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic          illegal;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  ctrl_pipe #(.REG_ADDR_W(RW), .HAZARD_EN(1), .CNT_W(CW)) dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_valid      (vld),
    .in_opcode     (op),
    .in_rs         (rs),
    .in_rt         (rt),
    .in_rd         (rd),
    .in_redirect   (redir),
    .out_stall     (stall),
    .out_ex_ctrl   (ex_ctrl),
    .out_mem_ctrl  (mem_ctrl),
    .out_wb_ctrl   (wb_ctrl),
    .out_ex_rd     (ex_rd),
    .out_mem_rd    (mem_rd),
    .out_wb_rd     (wb_rd),
    .out_illegal   (illegal),
    .out_stall_cnt (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input logic [3:0] o, input logic [RW-1:0] s,
                    input logic [RW-1:0] t, input logic [RW-1:0] d);
    vld = v; op = o; rs = s; rt = t; rd = d;
  endtask

  task automatic stall_pair(input int exp_cnt);
    id(1'b1, 4'b0001, 6'd1, 6'd0, 6'd9);
    tick();
    id(1'b1, 4'b0111, 6'd9, 6'd2, 6'd4);
    #1;
    chk("sat_stall", {31'b0, stall}, 32'd1);
    tick();
    id(1'b0, 4'b0000, 6'd0, 6'd0, 6'd0);
    chk("sat_cnt", {30'b0, cnt}, exp_cnt);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("rst_ex", {20'b0, ex_ctrl}, {20'b0, E_BUB});
    chk("rst_wb", {20'b0, wb_ctrl}, {20'b0, E_BUB});
    chk("rst_rd", {8'b0, ex_rd, mem_rd, wb_rd}, 32'd0);
    chk("rst_cnt", {30'b0, cnt}, 32'd0);
    chk("rst_ill", {31'b0, illegal}, 32'd0);
    rst = 1'b0;

    // ADD flows EX -> MEM -> WB
    id(1'b1, 4'b0100, 6'd1, 6'd2, 6'd3);
    tick();
    chk("add_ex", {20'b0, ex_ctrl}, {20'b0, E_ADD});
    chk("add_ex_rd", {26'b0, ex_rd}, 32'd3);
    id(1'b0, 4'b0000, 6'd0, 6'd0, 6'd0);
    tick();
    chk("add_mem", {20'b0, mem_ctrl}, {20'b0, E_ADD});
    chk("inv_ex", {20'b0, ex_ctrl}, {20'b0, E_BUB});
    tick();
    chk("add_wb", {20'b0, wb_ctrl}, {20'b0, E_ADD});
    chk("add_wb_rd", {26'b0, wb_rd}, 32'd3);

    // LD r5 then SUB reading r5: one stall cycle
    id(1'b1, 4'b0001, 6'd1, 6'd0, 6'd5);
    tick();
    chk("ld_ex", {20'b0, ex_ctrl}, {20'b0, E_LD});
    id(1'b1, 4'b0111, 6'd5, 6'd2, 6'd6);
    #1;
    chk("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    chk("lu_ex_bub", {20'b0, ex_ctrl}, {20'b0, E_BUB});
    chk("lu_mem_ld", {20'b0, mem_ctrl}, {20'b0, E_LD});
    chk("lu_cnt", {30'b0, cnt}, 32'd1);
    chk("lu_stall_end", {31'b0, stall}, 32'd0);
    tick();
    chk("lu_sub_ex", {20'b0, ex_ctrl}, {20'b0, E_SUB});
    chk("lu_sub_rd", {26'b0, ex_rd}, 32'd6);

    // r0 load and INC-reads-only-rs: no stall
    id(1'b1, 4'b0001, 6'd1, 6'd0, 6'd0);
    tick();
    id(1'b1, 4'b0100, 6'd0, 6'd0, 6'd7);
    #1;
    chk("r0_nostall", {31'b0, stall}, 32'd0);
    tick();
    chk("r0_add_ex", {20'b0, ex_ctrl}, {20'b0, E_ADD});
    id(1'b1, 4'b0001, 6'd1, 6'd0, 6'd5);
    tick();
    id(1'b1, 4'b0101, 6'd1, 6'd5, 6'd8);
    #1;
    chk("inc_nostall", {31'b0, stall}, 32'd0);
    tick();
    chk("inc_ex", {20'b0, ex_ctrl}, {20'b0, E_INC});
    chk("inc_cnt", {30'b0, cnt}, 32'd1);

    // BRZ reaches MEM with a load-use pair behind it, then redirect
    id(1'b1, 4'b1001, 6'd0, 6'd0, 6'd0);
    tick();
    id(1'b1, 4'b0001, 6'd1, 6'd0, 6'd5);
    tick();
    chk("br_mem", {20'b0, mem_ctrl}, {20'b0, E_BRZ});
    id(1'b1, 4'b0100, 6'd5, 6'd2, 6'd3);
    redir = 1'b1;
    #1;
    chk("rd_stall_low", {31'b0, stall}, 32'd0);
    tick();
    redir = 1'b0;
    id(1'b0, 4'b0000, 6'd0, 6'd0, 6'd0);
    chk("rd_ex_bub", {20'b0, ex_ctrl}, {20'b0, E_BUB});
    chk("rd_mem_bub", {20'b0, mem_ctrl}, {20'b0, E_BUB});
    chk("rd_cnt", {30'b0, cnt}, 32'd1);
    chk("rd_wb_brz", {20'b0, wb_ctrl}, {20'b0, E_BRZ});
    chk("rd_wb_br_bits", {30'b0, wb_ctrl[2], wb_ctrl[1]}, 32'd2);

    // Undefined opcode
    id(1'b1, 4'b1101, 6'd1, 6'd2, 6'd3);
    tick();
    chk("ill_pulse", {31'b0, illegal}, 32'd1);
    chk("ill_ex", {20'b0, ex_ctrl}, {20'b0, E_ILL});
    id(1'b0, 4'b0000, 6'd0, 6'd0, 6'd0);
    tick();
    chk("ill_pulse_end", {31'b0, illegal}, 32'd0);
    chk("ill_mem_wr", {30'b0, mem_ctrl[10], mem_ctrl[8]}, 32'd0);
    tick();
    chk("ill_wb_wr", {30'b0, wb_ctrl[10], wb_ctrl[8]}, 32'd0);

    // Four more stalls: 2, 3, then held at 3
    stall_pair(2);
    stall_pair(3);
    stall_pair(3);
    stall_pair(3);

    // Fill the pipe, then reset asynchronously between edges
    id(1'b1, 4'b0100, 6'd1, 6'd2, 6'd3);
    tick();
    id(1'b1, 4'b0001, 6'd1, 6'd0, 6'd5);
    tick();
    id(1'b1, 4'b0100, 6'd5, 6'd2, 6'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ex", {20'b0, ex_ctrl}, {20'b0, E_BUB});
    chk("arst_mem", {20'b0, mem_ctrl}, {20'b0, E_BUB});
    chk("arst_wb", {20'b0, wb_ctrl}, {20'b0, E_BUB});
    chk("arst_rd", {8'b0, ex_rd, mem_rd, wb_rd}, 32'd0);
    chk("arst_cnt", {30'b0, cnt}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
